// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command sequencer.
//   state_t       : sequencer states (S_IDLE, S_WDATA, S_BUS, S_RDUMMY)
//   CMD_WR_BIT    : command byte bit selecting write (1) or read (0)
//   CMD_BURST_BIT : command byte bit selecting auto-increment burst access
//   ADDR_W        : register address width
//   addr_next()   : burst address step, wraps 63 -> 0
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WDATA  = 2'd1,
        S_BUS    = 2'd2,
        S_RDUMMY = 2'd3
    } state_t;

    localparam int CMD_WR_BIT    = 7;
    localparam int CMD_BURST_BIT = 6;
    localparam int ADDR_W        = 6;

    // Natural overflow of the ADDR_W-bit sum gives the modulo-64 wrap.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] addr);
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/spi_rx_strobe.sv
// spi_rx_strobe: turns the synchronized rx_ready level into a one-cycle
// byte strobe and presents the byte that belongs to it.
//   clk_sys   in  : system clock
//   rst_n     in  : asynchronous active-low reset
//   rx_data   in  : synchronized received byte
//   rx_ready  in  : synchronized byte-ready level (rising edge = new byte)
//   strobe    out : high for the single cycle in which rx_ready rises
//   byte_data out : received byte; equals rx_data during the strobe cycle
//                   and holds the last captured byte otherwise
module spi_rx_strobe (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       strobe,
    output logic [7:0] byte_data
);

    logic       rx_ready_q;
    logic [7:0] byte_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            rx_ready_q <= rx_ready;
            if (strobe) begin
                byte_q <= rx_data;
            end
        end
    end

    assign strobe = rx_ready & ~rx_ready_q;

    // Bypass so the sequencer can act on the byte in the strobe cycle itself;
    // this keeps the strobe-to-output latency at exactly one clock.
    assign byte_data = strobe ? rx_data : byte_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI bytes into register-bus reads/writes, with
// single and auto-increment burst access and an inter-byte timeout that
// re-frames the link (there is no chip select).
// Optional feature macro: SPI_CMD_ERR_CNT_EN (saturating error counter).
//   clk_sys   in  : system clock
//   rst_n     in  : asynchronous active-low reset
//   rx_data   in  : synchronized received byte
//   rx_ready  in  : synchronized byte-ready level
//   reg_req   out : bus request, held until reg_ack
//   reg_we    out : 1 = write, 0 = read
//   reg_addr  out : register address
//   reg_wdata out : write data
//   reg_ack   in  : single-cycle completion
//   reg_rdata in  : read data, valid with reg_ack
//   tx_data   out : byte for the SPI transmit shifter
//   tx_load   out : one-cycle pulse, tx_data updated
//   overrun   out : one-cycle pulse, byte dropped because the bus was busy
//   timeout   out : one-cycle pulse, frame abandoned
//   err_cnt   out : saturating count of overrun/timeout events (0 if not built)
//
// Bus handshake: reg_req rises together with stable reg_we/reg_addr/reg_wdata
// and stays high with those fields frozen until the cycle in which reg_ack
// is sampled high; reg_req is low from the following cycle. reg_ack is only
// honoured while a request is outstanding (state S_BUS).
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    output logic                 reg_req,
    output logic                 reg_we,
    output logic [ADDR_W-1:0]    reg_addr,
    output logic [7:0]           reg_wdata,
    input  logic                 reg_ack,
    input  logic [7:0]           reg_rdata,
    output logic [7:0]           tx_data,
    output logic                 tx_load,
    output logic                 overrun,
    output logic                 timeout,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             burst;
    logic             strobe;
    logic [7:0]       byte_data;
    logic [TMR_W-1:0] timer;
    logic             timer_expired;

    spi_rx_strobe u_rx_strobe (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .strobe    (strobe),
        .byte_data (byte_data)
    );

    // Inter-byte timer: only runs while waiting for the next byte of a frame.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (strobe || state == S_IDLE || state == S_BUS) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign timer_expired = (timer == TMR_LAST);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            burst     <= 1'b0;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (strobe) begin
                        reg_addr <= byte_data[ADDR_W-1:0];
                        burst    <= byte_data[CMD_BURST_BIT];
                        if (byte_data[CMD_WR_BIT]) begin
                            reg_we <= 1'b1;
                            state  <= S_WDATA;
                        end else begin
                            reg_we  <= 1'b0;
                            reg_req <= 1'b1;
                            state   <= S_BUS;
                        end
                    end
                end
                S_WDATA: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (strobe) begin
                        reg_wdata <= byte_data;
                        reg_we    <= 1'b1;
                        reg_req   <= 1'b1;
                        state     <= S_BUS;
                    end else if (timer_expired) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_BUS: begin
                    // The bus fields stay frozen; a byte here is simply lost.
                    if (strobe) begin
                        overrun <= 1'b1;
                    end
                    if (reg_ack) begin
                        reg_req <= 1'b0;
                        if (!reg_we) begin
                            tx_data <= reg_rdata;
                            tx_load <= 1'b1;
                        end
                        if (burst) begin
                            reg_addr <= addr_next(reg_addr);
                            state    <= reg_we ? S_WDATA : S_RDUMMY;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RDUMMY: begin
                    // Dummy byte content is irrelevant; it only paces the read.
                    if (strobe) begin
                        reg_we  <= 1'b0;
                        reg_req <= 1'b1;
                        state   <= S_BUS;
                    end else if (timer_expired) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_CMD_ERR_CNT_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((overrun || timeout) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: self-checking bench for spi_cmd_ctrl. Frames of bytes
// are driven on rx_data/rx_ready, a bus responder answers requests after a
// random or fixed delay, and a frame-level model predicts the bus
// transactions, transmit bytes, overrun/timeout pulses and error count.
module tb_spi_cmd_ctrl;

    localparam int T      = 40;
    localparam int ERR_W  = 8;

    logic             clk_sys = 1'b0;
    logic             rst_n;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             reg_req;
    logic             reg_we;
    logic [5:0]       reg_addr;
    logic [7:0]       reg_wdata;
    logic             reg_ack = 1'b0;
    logic [7:0]       reg_rdata = 8'h00;
    logic [7:0]       tx_data;
    logic             tx_load;
    logic             overrun;
    logic             timeout;
    logic [ERR_W-1:0] err_cnt;

    spi_cmd_ctrl #(
        .TIMEOUT_CYCLES (T),
        .ERR_CNT_W      (ERR_W)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .overrun   (overrun),
        .timeout   (timeout),
        .err_cnt   (err_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [14:0] exp_q[$];     // {we, addr, wdata (0 for reads)}
    logic [14:0] obs_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rdata_q[$];
    logic [7:0]  frame_b [0:7];

    int tx_cnt = 0, ovr_cnt = 0, to_cnt = 0, to_cyc = 0;
    int exp_ovr = 0, exp_to = 0, unstable = 0;
    int ack_done_cnt = 0, last_ack_cyc = 0;
    int ack_delay = -1;        // -1: random 0..4 cycles
    bit poke_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int exp_err();
        int ev;
        ev = exp_ovr + exp_to;
`ifdef SPI_CMD_ERR_CNT_EN
        return (ev > 255) ? 255 : ev;
`else
        return 0;
`endif
    endfunction

    // ---------------- bus responder ----------------
    bit busy = 1'b0, acking = 1'b0;
    int wait_left = 0;
    always @(negedge clk_sys) begin
        if (acking) begin
            reg_ack = 1'b0;
            acking = 1'b0;
            busy = 1'b0;
            last_ack_cyc = cyc;
            ack_done_cnt++;
        end else if (poke_ack) begin
            reg_ack = 1'b1;
            reg_rdata = 8'hEE;
            poke_ack = 1'b0;
            acking = 1'b1;
            ack_done_cnt--;    // not a real access; the clear branch adds it back
        end else if (busy && !reg_req) begin
            busy = 1'b0;       // request abandoned by reset
        end else if (busy) begin
            if (wait_left == 0) begin
                reg_ack = 1'b1;
                if (!reg_we && rdata_q.size() > 0) reg_rdata = rdata_q.pop_front();
                else reg_rdata = 8'($urandom);
                if (!reg_we) tx_exp_q.push_back(reg_rdata);
                acking = 1'b1;
            end else begin
                wait_left--;
            end
        end else if (reg_req && rst_n) begin
            busy = 1'b1;
            wait_left = (ack_delay < 0) ? $urandom_range(0, 4) : ack_delay;
        end
    end

    // ---------------- monitor ----------------
    logic        prev_req = 1'b0;
    logic [14:0] cap;
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (reg_req && !prev_req) begin
                cap = {reg_we, reg_addr, reg_we ? reg_wdata : 8'h00};
                obs_q.push_back(cap);
            end else if (reg_req && ({reg_we, reg_addr, reg_we ? reg_wdata : 8'h00} != cap)) begin
                unstable++;
            end
            if (tx_load) begin
                tx_cnt++;
                if (tx_exp_q.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else check("tx_data", {24'h0, tx_data}, {24'h0, tx_exp_q.pop_front()});
            end
            if (overrun) ovr_cnt++;
            if (timeout) begin
                to_cnt++;
                to_cyc = cyc;
            end
        end
        prev_req = reg_req;
    end

    // ---------------- model ----------------
    // Expected bus accesses of a frame; returns the number of reads.
    function automatic int model_frame(input int n);
        logic [7:0] cmd;
        logic [5:0] a;
        int reads;
        cmd = frame_b[0];
        a = cmd[5:0];
        reads = 0;
        if (cmd[7]) begin
            for (int i = 1; i < n; i++) begin
                exp_q.push_back({1'b1, a, frame_b[i]});
                a = a + 6'd1;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b0, a, 8'h00});
                a = a + 6'd1;
                reads++;
            end
        end
        return reads;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys);
        rx_data = b;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk_sys);
        rx_ready = 1'b0;
    endtask

    task automatic wait_acks(input int target);
        for (int k = 0; k < 200 && ack_done_cnt < target; k++) @(negedge clk_sys);
        check("ack_wait", ack_done_cnt >= target, 1);
    endtask

    task automatic wait_timeout(input int to0);
        for (int k = 0; k < T + 60 && to_cnt == to0; k++) @(negedge clk_sys);
        check("timeout_seen", to_cnt, to0 + 1);
        check("timeout_latency", to_cyc - last_ack_cyc, T);
        exp_to++;
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_txn_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_txn"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        check({tag, "_ovr"}, ovr_cnt, exp_ovr);
        check({tag, "_to"}, to_cnt, exp_to);
        check({tag, "_stable"}, unstable, 0);
        check({tag, "_err_cnt"}, err_cnt, exp_err());
    endtask

    task automatic run_frame(input string tag, input int n);
        int reads, tx0, to0, base, k;
        bit wr, bst;
        wr = frame_b[0][7];
        bst = frame_b[0][6];
        reads = model_frame(n);
        tx0 = tx_cnt;
        to0 = to_cnt;
        base = ack_done_cnt;
        k = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(frame_b[i]);
            if (i > 0 || !wr) begin
                k++;
                wait_acks(base + k);
            end
        end
        if (bst) wait_timeout(to0);
        else repeat (3) @(negedge clk_sys);
        check({tag, "_tx_count"}, tx_cnt - tx0, reads);
        compare_frame(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int to0, base, c;
        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_ready = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("rst_req", reg_req, 0);
        check("rst_fields", {reg_we, reg_addr, reg_wdata}, 0);
        check("rst_tx", {tx_data, tx_load, overrun, timeout}, 0);
        check("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // single write
        frame_b[0] = 8'h85; frame_b[1] = 8'h3C;
        run_frame("single_wr", 2);

        // single read
        rdata_q.push_back(8'hA7);
        frame_b[0] = 8'h12;
        run_frame("single_rd", 1);

        // burst write across the address wrap, ends by timeout
        frame_b[0] = 8'hFE; frame_b[1] = 8'h11; frame_b[2] = 8'h22; frame_b[3] = 8'h33;
        run_frame("burst_wr", 4);

        // burst read with two dummy bytes
        rdata_q.push_back(8'h01); rdata_q.push_back(8'h02); rdata_q.push_back(8'h03);
        frame_b[0] = 8'h7F; frame_b[1] = 8'h00; frame_b[2] = 8'h00;
        run_frame("burst_rd", 3);

        // overrun: a byte lands while the ack is withheld
        ack_delay = 20;
        exp_q.push_back({1'b1, 6'h0A, 8'h55});
        base = ack_done_cnt;
        send_byte(8'h8A);
        send_byte(8'h55);
        send_byte(8'h99);
        exp_ovr++;
        wait_acks(base + 1);
        ack_delay = -1;
        repeat (3) @(negedge clk_sys);
        compare_frame("overrun");

        // byte arriving on the very cycle the timer would expire wins
        exp_q.push_back({1'b1, 6'h08, 8'hAA});
        exp_q.push_back({1'b1, 6'h09, 8'hBB});
        to0 = to_cnt;
        base = ack_done_cnt;
        send_byte(8'hC8);
        send_byte(8'hAA);
        wait_acks(base + 1);
        @(negedge clk_sys);
        c = last_ack_cyc;
        for (int k = 0; k < 2 * T && cyc < c + T - 1; k++) @(negedge clk_sys);
        rx_data = 8'hBB;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk_sys);
        rx_ready = 1'b0;
        wait_acks(base + 2);
        check("strobe_wins_no_to", to_cnt, to0);
        wait_timeout(to0);
        compare_frame("edge_expiry");

        // ack while idle is ignored
        c = tx_cnt;
        poke_ack = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("idle_ack_tx", tx_cnt, c);
        check("idle_ack_req", obs_q.size(), 0);

        // random frames
        for (int f = 0; f < 24; f++) begin
            int n;
            frame_b[0] = 8'($urandom);
            if (frame_b[0][6]) n = frame_b[0][7] ? $urandom_range(2, 5) : $urandom_range(1, 4);
            else n = frame_b[0][7] ? 2 : 1;
            for (int i = 1; i < n; i++) frame_b[i] = 8'($urandom);
            run_frame("rand", n);
        end

        // reset in the middle of a burst read
        ack_delay = 1000;
        exp_q.push_back({1'b0, 6'h00, 8'h00});
        send_byte(8'h40);
        for (int k = 0; k < 10 && !reg_req; k++) @(negedge clk_sys);
        check("pre_rst_req", reg_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", reg_req, 0);
        check("async_rst_fields", {reg_we, reg_addr, reg_wdata}, 0);
        check("async_rst_tx", {tx_data, tx_load, overrun, timeout}, 0);
        check("async_rst_err", err_cnt, 0);
        exp_ovr = 0;
        exp_to = 0;
        ovr_cnt = 0;
        to_cnt = 0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        ack_delay = -1;
        repeat (2) @(negedge clk_sys);
        compare_frame("mid_rst");
        frame_b[0] = 8'h05;
        run_frame("post_rst", 1);

        check("tx_exp_drained", tx_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
